load_store_unit: RTL and testbench

Multi-cycle load/store unit between the processor core's execute/writeback path and a handshaked data-memory bus. It replaces the core's direct combinational data-memory access. The core presents a memory request (address = ALU result, store data = rs2 value, access mode = funct3). The unit steers store bytes, issues one bus transaction, sign/zero-extends load data, and holds `stall` high so the core freezes PC and register-file write until the access completes.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 73 +++++++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access modes, FSM states, bus request payload.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [STRB_W-1:0] wstrb;
        logic [XLEN-1:0]   wdata;
    } bus_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store byte steering, load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_mode,
    input  logic              i_store,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rword,
    output logic              o_ok_c,
    output logic [STRB_W-1:0] o_wstrb_c,
    output logic [XLEN-1:0]   o_wdata_c,
    output logic [XLEN-1:0]   o_ldata_c
);

    mem_mode_e   w_mode;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mode = mem_mode_e'(i_mode);
    assign w_byte = 8'(i_rword >> {i_off, 3'b000});
    assign w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];

    // Mode must exist for this direction and the address must be aligned to the access size
    always_comb begin
        o_ok_c = 1'b0;
        case (w_mode)
            MEM_B:   o_ok_c = 1'b1;
            MEM_H:   o_ok_c = ~i_off[0];
            MEM_W:   o_ok_c = (i_off == 2'b00);
            MEM_BU:  o_ok_c = ~i_store;
            MEM_HU:  o_ok_c = ~i_store & ~i_off[0];
            default: o_ok_c = 1'b0;
        endcase
    end

    // Replicate store data across lanes and select strobes; reads carry no strobes
    always_comb begin
        o_wstrb_c = '0;
        o_wdata_c = '0;
        if (i_store) begin
            case (w_mode)
                MEM_B: begin
                    o_wdata_c = {4{i_wdata[7:0]}};
                    o_wstrb_c = 4'b0001 << i_off;
                end
                MEM_H: begin
                    o_wdata_c = {2{i_wdata[15:0]}};
                    o_wstrb_c = i_off[1] ? 4'b1100 : 4'b0011;
                end
                MEM_W: begin
                    o_wdata_c = i_wdata;
                    o_wstrb_c = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    // Pick the addressed byte/half from the read word and extend it
    always_comb begin
        o_ldata_c = '0;
        case (w_mode)
            MEM_B:   o_ldata_c = {{24{w_byte[7]}}, w_byte};
            MEM_BU:  o_ldata_c = {24'd0, w_byte};
            MEM_H:   o_ldata_c = {{16{w_half[15]}}, w_half};
            MEM_HU:  o_ldata_c = {16'd0, w_half};
            MEM_W:   o_ldata_c = i_rword;
            default: o_ldata_c = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one handshaked bus transaction per core access, stalling the core.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    bus_req_t          r_req;
    logic              r_req_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   w_rdata_nxt;
    logic              r_misalign;
    logic              w_misalign_nxt;
    logic              r_bus_err;
    logic              w_bus_err_nxt;
    logic              w_req;
    logic              w_ok;
    logic              w_tmo;
    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ldata;

    assign w_req = rd_en | wr_en;
    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .i_off     (addr[1:0]),
        .i_mode    (mem_acc_mode),
        .i_store   (wr_en),
        .i_wdata   (wdata),
        .i_rword   (bus_rsp_rdata),
        .o_ok_c    (w_ok),
        .o_wstrb_c (w_wstrb),
        .o_wdata_c (w_wdata),
        .o_ldata_c (w_ldata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the status/data values latched on entry to DONE
    always_comb begin
        w_state_nxt    = r_state;
        w_misalign_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;
        w_rdata_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_ok) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt    = DONE;
                        w_misalign_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (w_tmo) begin
                    w_state_nxt   = DONE;
                    w_bus_err_nxt = 1'b1;
                end else if (bus_req_ready) begin
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                if (bus_rsp_valid) begin
                    w_state_nxt = DONE;
                    if (bus_rsp_err) begin
                        w_bus_err_nxt = 1'b1;
                    end else if (!r_req.we) begin
                        w_rdata_nxt = w_ldata;
                    end
                end else if (w_tmo) begin
                    w_state_nxt   = DONE;
                    w_bus_err_nxt = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus request fields, timeout counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= '0;
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
            r_bus_err  <= w_bus_err_nxt;
            if (w_state_nxt == DONE) begin
                r_rdata <= w_rdata_nxt;
            end
            if ((r_state == IDLE) && (w_state_nxt == REQ)) begin
                r_req.we    <= wr_en;
                r_req.addr  <= {addr[31:2], 2'b00};
                r_req.wstrb <= w_wstrb;
                r_req.wdata <= w_wdata;
                r_req_valid <= 1'b1;
                r_cnt       <= '0;
            end else if ((r_state == REQ) || (r_state == RSP)) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_state_nxt != REQ) begin
                    r_req_valid <= 1'b0;
                end
            end
        end
    end

    assign stall         = w_req & (r_state != DONE) & ~rst;
    assign rdata         = r_rdata;
    assign misalign      = r_misalign;
    assign bus_err       = r_bus_err;
    assign bus_req_valid = r_req_valid;
    assign bus_we        = r_req.we;
    assign bus_addr      = r_req.addr;
    assign bus_wstrb     = r_req.wstrb;
    assign bus_wdata     = r_req.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random accesses against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [2:0]  mem_acc_mode;
    logic        bus_req_ready, bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;

    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        stall, misalign, bus_err, bus_req_valid, bus_we;
    logic [3:0]  bus_wstrb;

    logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
    logic        stall_t, misalign_t, bus_err_t, bus_req_valid_t, bus_we_t;
    logic [3:0]  bus_wstrb_t;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .mem_acc_mode(mem_acc_mode), .wdata(wdata), .rdata(rdata), .stall(stall),
        .misalign(misalign), .bus_err(bus_err), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    load_store_unit #(.TIMEOUT_CYCLES(8)) u_dut_t (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .mem_acc_mode(mem_acc_mode), .wdata(wdata), .rdata(rdata_t), .stall(stall_t),
        .misalign(misalign_t), .bus_err(bus_err_t), .bus_req_valid(bus_req_valid_t),
        .bus_req_ready(bus_req_ready), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
        .bus_wstrb(bus_wstrb_t), .bus_wdata(bus_wdata_t), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: legality of a mode/address pair for a direction
    function automatic logic m_legal(input logic st, input logic [2:0] md, input logic [31:0] a);
        case (md)
            3'd0:    return 1'b1;
            3'd1:    return (a % 2) == 0;
            3'd2:    return (a % 4) == 0;
            3'd4:    return !st;
            3'd5:    return !st && ((a % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] md, input logic [31:0] a);
        case (md)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] md, input logic [31:0] wd);
        case (md)
            3'd0:    return (wd % 256) * 32'h0101_0101;
            3'd1:    return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] md, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w / (32'd1 << (8 * (a % 4)))) % 256;
        h = (w / (32'd1 << (16 * ((a % 4) / 2)))) % 65536;
        case (md)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    // One core access on the main instance, acting as core and bus responder
    task automatic do_access(input string tag, input logic st, input logic [2:0] md,
                             input logic [31:0] a, input logic [31:0] wd, input int rdy_dly,
                             input int rsp_dly, input logic [31:0] rw, input logic re);
        logic        ok, e_err;
        logic [31:0] e_rdata;
        int          stall_cnt, req_cyc, rsp_wait, cyc, e_stall;
        bit          in_rsp, fin;
        ok      = m_legal(st, md, a);
        e_err   = ok && re;
        e_rdata = (ok && !st && !re) ? m_load(md, a, rw) : 32'd0;
        e_stall = ok ? (2 + rdy_dly + rsp_dly + 1) : 1;
        wr_en = st;
        rd_en = st ? 1'($urandom_range(0, 1)) : 1'b1;
        addr = a;
        mem_acc_mode = md;
        wdata = wd;
        stall_cnt = 0; req_cyc = 0; rsp_wait = 0; cyc = 0; in_rsp = 0; fin = 0;
        while (!fin && cyc < 300) begin
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'($urandom_range(0, 1));
            bus_rsp_rdata = $urandom;
            bus_rsp_err   = 1'($urandom_range(0, 1));
            if (in_rsp) begin
                bus_rsp_valid = (rsp_wait == rsp_dly);
                bus_rsp_rdata = bus_rsp_valid ? rw : $urandom;
                bus_rsp_err   = bus_rsp_valid ? re : 1'b0;
                rsp_wait++;
            end else if (bus_req_valid) begin
                chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
                chk({tag, "_we"}, 32'(bus_we), 32'(st));
                chk({tag, "_wstrb"}, 32'(bus_wstrb), st ? 32'(m_strb(md, a)) : 32'd0);
                if (st) chk({tag, "_wdata"}, bus_wdata, m_wdata(md, wd));
                bus_req_ready = (req_cyc == rdy_dly);
                req_cyc++;
            end
            #1;
            if (!stall) fin = 1;
            else stall_cnt++;
            if (!fin && bus_req_valid && bus_req_ready) in_rsp = 1;
            if (!fin) step();
            cyc++;
        end
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(e_stall));
        chk({tag, "_req_cycles"}, 32'(req_cyc), ok ? 32'(rdy_dly + 1) : 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'(!ok));
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(e_err));
        chk({tag, "_rdata"}, rdata, e_rdata);
        rd_en = 1'b0; wr_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        step();
        chk({tag, "_pulse_end"}, 32'({misalign, bus_err, stall, bus_req_valid}), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h0; mem_acc_mode = 3'd2; wdata = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_rdata = 32'h0;
        step(); step();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ctrl", 32'({bus_req_valid, bus_we, misalign, bus_err}), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rd_en = 1'b0;
        rst = 1'b0;
        step();

        do_access("sw",      1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        do_access("lb",      1'b0, 3'd0, 32'h203, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
        do_access("lbu",     1'b0, 3'd4, 32'h203, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
        do_access("sh",      1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 0, 0, 32'h0, 1'b0);
        do_access("lw_mis",  1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
        do_access("ld_err",  1'b0, 3'd2, 32'h040, 32'h0, 10, 0, 32'h55AA_55AA, 1'b1);
        do_access("lh_sx",   1'b0, 3'd1, 32'h302, 32'h0, 1, 2, 32'h9876_0001, 1'b0);
        do_access("lhu",     1'b0, 3'd5, 32'h302, 32'h0, 0, 1, 32'h9876_0001, 1'b0);
        do_access("sbu_ill", 1'b1, 3'd4, 32'h010, 32'hFF, 0, 0, 32'h0, 1'b0);
        do_access("md3_ill", 1'b0, 3'd3, 32'h010, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0);
        do_access("sb3",     1'b1, 3'd0, 32'h7, 32'h1234_56A5, 2, 1, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      $urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      $urandom, ($urandom_range(0, 7) == 0));
        end

        // Timeout on the short-timeout instance: load with no handshake at all
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        rd_en = 1'b1; mem_acc_mode = 3'd2; addr = 32'h300;
        #1;
        n = 0;
        while (stall_t && n < 50) begin
            n++;
            step();
        end
        chk("tmo_stall_cycles", 32'(n), 32'd9);
        chk("tmo_bus_err", 32'(bus_err_t), 32'd1);
        chk("tmo_rdata", rdata_t, 32'd0);
        chk("tmo_misalign", 32'(misalign_t), 32'd0);
        chk("tmo_req_valid", 32'(bus_req_valid_t), 32'd0);
        rd_en = 1'b0;
        step();
        chk("tmo_err_pulse", 32'(bus_err_t), 32'd0);

        // Reset while the next access sits in RSP; the late response must be ignored
        rd_en = 1'b1; addr = 32'h304; bus_req_ready = 1'b1;
        step();
        chk("rstm_req_valid", 32'(bus_req_valid_t), 32'd1);
        step();
        chk("rstm_in_rsp", 32'({bus_req_valid_t, stall_t}), 32'b01);
        rst = 1'b1; bus_req_ready = 1'b0;
        #1;
        chk("rstm_stall_in_rst", 32'(stall_t), 32'd0);
        step();
        chk("rstm_ctrl", 32'({bus_req_valid_t, bus_we_t, misalign_t, bus_err_t}), 32'd0);
        chk("rstm_addr", bus_addr_t, 32'd0);
        chk("rstm_rdata", rdata_t, 32'd0);
        rst = 1'b0; rd_en = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1234_5678; bus_rsp_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("late_rsp_t%0d", k), 32'({stall_t, misalign_t, bus_err_t, bus_req_valid_t}), 32'd0);
            chk($sformatf("late_rdata_t%0d", k), rdata_t, 32'd0);
            chk($sformatf("late_rsp_m%0d", k), 32'({stall, misalign, bus_err, bus_req_valid}), 32'd0);
        end
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
